// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial ID-sequence detector.
// Holds the pattern length, the default target pattern and the word/counter types
// used by the detector.
package seq_det_pkg;

  // Pattern length in bits; the detector is built for exactly this width.
  localparam int unsigned SEQ_LEN = 12;

  typedef logic [SEQ_LEN-1:0] seq_word_t;

  // BCD of 735 (0111_0011_0101), received MSB first.
  localparam seq_word_t SEQ_DEFAULT = 12'h735;

  // Valid-bit counter: must be able to hold SEQ_LEN.
  localparam int unsigned CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  // Counter saturates here once a full window of bits has been seen.
  localparam cnt_t CNT_MAX = cnt_t'(SEQ_LEN);

  // Counter value at which the incoming bit completes the first full window.
  localparam cnt_t CNT_ARM = cnt_t'(SEQ_LEN - 1);

endpackage

// File: rtl/seq_23735.sv
// Serial 12-bit pattern detector.
// Shifts one bit per clock from seq into a history register (first bit ends up as
// the MSB) and raises a registered one-cycle pulse on out when the newest 12 bits
// equal SEQ. Detection overlaps: every bit that completes a match fires, no matter
// what fired earlier. A saturating counter suppresses detection until 12 bits have
// been sampled since reset, so the cleared history can never match.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset; clears history, counter and out
//   seq   - serial data bit, sampled on the rising edge of clk
//   out   - registered detect flag, high for one cycle per match
module seq_23735
  import seq_det_pkg::*;
#(
  parameter seq_word_t SEQ = SEQ_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic seq,
  output logic out
);

  seq_word_t hist_q, hist_d;
  cnt_t      cnt_q, cnt_d;
  logic      out_q, out_d;
  logic      armed;

  always_comb begin
    hist_d = {hist_q[SEQ_LEN-2:0], seq};
    cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + cnt_t'(1);
    // The bit arriving now is at least the 12th since reset, so the window is full.
    armed  = (cnt_q >= CNT_ARM);
    // Written as an if so that an unknown seq resolves to no detection.
    out_d  = 1'b0;
    if (armed && (hist_d == SEQ)) begin
      out_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_seq_23735.sv
// Directed bench for seq_23735. A second instance with the pattern overridden to
// all zeros checks the warm-up gate. Bits are driven on the falling edge and out is
// sampled 1 time unit after the rising edge.
module tb_seq_23735;

  logic clk;
  logic reset;
  logic seq;
  logic out;
  logic out_zero;

  int checks;
  int failures;

  seq_23735 dut (
    .clk  (clk),
    .reset(reset),
    .seq  (seq),
    .out  (out)
  );

  seq_23735 #(
    .SEQ(12'h000)
  ) dut_zero (
    .clk  (clk),
    .reset(reset),
    .seq  (seq),
    .out  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Hold reset low for two rising edges, check the cleared output, then release
  // between edges so the next falling edge starts a fresh bit.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_bit({tag, "_rst"}, out, 1'b0);
    check_bit({tag, "_rst_zero"}, out_zero, 1'b0);
    #2;
    reset = 1'b1;
  endtask

  // Drive n bits of vec MSB first; exp[i] is the required out after the edge that
  // samples bit i. use_zero selects the all-zeros-pattern instance.
  task automatic drive_vec(input string tag, input logic [31:0] vec, input int n,
                           input logic [31:0] exp, input bit use_zero);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      seq = vec[n-1-i];
      @(posedge clk);
      #1;
      check_bit($sformatf("%s[%0d]", tag, i), use_zero ? out_zero : out, exp[i]);
    end
  endtask

  initial begin
    logic [31:0] v;
    checks   = 0;
    failures = 0;
    seq      = 1'b0;
    reset    = 1'b0;

    // 1: single match, pulse one cycle after the 12th bit, then drops.
    do_reset("t1");
    v = {19'b0, 12'h735, 1'b0};
    drive_vec("t1_735", v, 13, 32'h0000_0800, 1'b0);

    // 2: pattern shifted left never matches.
    do_reset("t2");
    v = {18'b0, 12'hE6A, 2'b00};
    drive_vec("t2_e6a", v, 14, 32'h0, 1'b0);

    // 3: pattern shifted right never matches.
    do_reset("t3");
    v = {18'b0, 12'h39A, 2'b00};
    drive_vec("t3_39a", v, 14, 32'h0, 1'b0);

    // 4: overlapping re-detection 10 bits after the first match.
    do_reset("t4");
    v = {9'b0, 12'h735, 10'h335, 1'b0};
    drive_vec("t4_ovl", v, 23, 32'h0020_0800, 1'b0);

    // 5a: asynchronous reset clears a high out immediately.
    do_reset("t5");
    v = {20'b0, 12'h735};
    drive_vec("t5_735", v, 12, 32'h0000_0800, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_bit("t5_async_clr", out, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;

    // 5b: partial match discarded by a mid-sequence reset.
    v = {21'b0, 11'h39A};
    drive_vec("t5_part", v, 11, 32'h0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_bit("t5_mid_rst", out, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    v = 32'h1;
    drive_vec("t5_last", v, 1, 32'h0, 1'b0);
    // Continuing with a full pattern after the stray bit still detects.
    v = {20'b0, 12'h735};
    drive_vec("t5_again", v, 12, 32'h0000_0800, 1'b0);

    // 6: warm-up gate with an all-zeros pattern.
    do_reset("t6");
    v = 32'h0;
    drive_vec("t6_zero", v, 16, 32'h0000_F800, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_23735.md
Name: seq_23735

Overview:
Serial 12-bit pattern detector for the ID-sequence check block. Receives one bit per clock on `seq`. Asserts a registered (Moore) pulse on `out` when the last 12 sampled bits equal the configured pattern, with the first-sampled bit as the MSB. Detection is overlapping, and the block is a leaf with no bus handshake.

Parameters:
- SEQ_LEN, 12: pattern length in bits; fixed at 12 for this block.
- SEQ, 12'h735: target pattern. It is the BCD of 735 (0111_0011_0101) and is received MSB first.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset. reset=0 clears all state immediately.
- seq, input, 1: serial data bit. Sampled on the rising edge of clk and driven by the source on the falling edge.
- out, output, 1: detect flag. Registered, high for exactly one clock per match.

Behaviour:
- Reset (reset=0, asynchronous):
  - hist (12-bit history) = 0.
  - cnt (4-bit valid-bit counter) = 0.
  - out = 0.
  - Held while reset=0; `seq` is ignored during reset.
- Each rising clk edge with reset=1:
  - hist <= {hist[10:0], seq}.
  - cnt <= min(cnt+1, 12), saturating at 12.
  - out <= (cnt >= 11) && ({hist[10:0], seq} == SEQ).
- Latency:
  - out rises right after the clock edge that samples the 12th (LSB) pattern bit.
  - It is visible from that edge until the next rising edge.
  - At the sampling edge itself, out still shows the previous (0) value.
- Pulse width: out stays high one cycle only. It drops on the next edge unless that edge completes another match.
- Overlap:
  - A match ending on the current bit is detected regardless of earlier matches.
  - SEQ has a 2-bit border ("01"), so re-detection is possible 10 bits after a match.
- Warm-up:
  - No detection until 12 bits have been sampled since reset release (cnt gate).
  - Reset contents of hist therefore never produce a false match, even for SEQ = 0.
- Reset mid-sequence: any partial match is discarded. A full 12 new bits are needed after release.
- Unknown input: if seq is X/Z while reset=1, out is computed as 0 for that edge. hist takes the value as sampled; no X-propagation guarantees are required.
- Reset deassertion is synchronised by the system. No internal reset synchroniser is required.
- Equivalent 13-state FSM (S0..S12, KMP transitions) is an acceptable alternative implementation if cycle behaviour is identical.

Decomposition:
- Shared package seq_det_pkg holds:
  - localparam SEQ_LEN = 12.
  - localparam SEQ_DEFAULT = 12'h735.
  - typedef seq_word_t (logic [SEQ_LEN-1:0]).
- No sub-module is needed. The history shift register, counter and comparator sit in one module. If split, use one sub-module seq_shift_hist, holding the shift register plus the saturating counter.

Test Plan:
1. Reset 0 for 2 cycles, release, then drive 12'h735 MSB first (0,1,1,1,0,0,1,1,0,1,0,1). Required: out=0 at every sampling edge; out=1 in the cycle after the 12th bit; out=0 one cycle later.
2. After reset, drive 12'hE6A (735<<1 truncated): 1,1,1,0,0,1,1,0,1,0,1,0. Required: out=0 throughout and after.
3. After reset, drive 12'h39A (735>>1): 0,0,1,1,1,0,0,1,1,0,1,0. Required: out=0 throughout and after.
4. Overlap: drive 735 pattern, then the 10 bits 1,1,0,0,1,1,0,1,0,1. Required: out=1 after bit 12 and again after bit 22; out=0 in all other cycles.
5. Reset mid-sequence: drive the first 11 bits of 735, pulse reset=0 asynchronously between edges, release, then drive the 12th bit 1. Required: out=1 never; out goes 0 immediately on reset assertion.
6. Warm-up: release reset with SEQ overridden to 12'h000 and drive 0s. Required: first out=1 only after the 12th sampled 0; it then stays 1 each cycle while 0s continue.
